// File: rtl/traffic_pkg.sv
// Shared codes, default timings and the timing payload for the traffic-light mode controller.
package traffic_pkg;

  localparam int unsigned TIME_W = 7;

  localparam logic [2:0] EN_OFF    = 3'b000;
  localparam logic [2:0] EN_AUTO   = 3'b100;
  localparam logic [2:0] EN_MANUAL = 3'b010;
  localparam logic [2:0] EN_FLASH  = 3'b001;

  localparam logic [2:0] LS_GR = 3'd3;
  localparam logic [2:0] LS_YR = 3'd4;
  localparam logic [2:0] LS_RG = 3'd5;
  localparam logic [2:0] LS_RY = 3'd6;

  localparam int unsigned DEFAULT_GREEN    = 30;
  localparam int unsigned DEFAULT_YELLOW   = 3;
  localparam int unsigned DEFAULT_MIN_G    = 5;
  localparam int unsigned DEFAULT_MIN_Y    = 2;
  localparam int unsigned MAX_TIME         = 99;
  localparam int unsigned DEFAULT_CLEAR    = 2;

  typedef struct packed {
    logic [TIME_W-1:0] green;
    logic [TIME_W-1:0] yellow;
  } timing_t;

  // Sum is widened to 8 bits so large offers cannot wrap into the legal range.
  function automatic logic timing_ok(input timing_t t, input int unsigned min_g,
                                     input int unsigned min_y, input int unsigned max_t);
    logic [7:0] sum;
    sum = {1'b0, t.green} + {1'b0, t.yellow};
    return (t.green >= 7'(min_g)) && (t.yellow >= 7'(min_y)) && (sum <= 8'(max_t));
  endfunction

endpackage

// File: rtl/timing_cfg_reg.sv
// Timing handshake, validation, pending slot and active green/yellow/red registers.
module timing_cfg_reg
  import traffic_pkg::*;
#(
  parameter int unsigned DEF_GREEN  = DEFAULT_GREEN,
  parameter int unsigned DEF_YELLOW = DEFAULT_YELLOW,
  parameter int unsigned MIN_GREEN  = DEFAULT_MIN_G,
  parameter int unsigned MIN_YELLOW = DEFAULT_MIN_Y,
  parameter int unsigned MAX_T      = MAX_TIME
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [TIME_W-1:0] cfg_green,
  input  logic [TIME_W-1:0] cfg_yellow,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic              commit,
  output logic              pending,
  output logic [TIME_W-1:0] green_time,
  output logic [TIME_W-1:0] yellow_time,
  output logic [TIME_W-1:0] red_time
);

  timing_t offer;
  timing_t pend;

  assign offer = '{green: cfg_green, yellow: cfg_yellow};

  // Commit and acceptance are exclusive: a pending entry holds cfg_ready low.
  always_ff @(posedge clk) begin
    if (reset) begin
      green_time  <= TIME_W'(DEF_GREEN);
      yellow_time <= TIME_W'(DEF_YELLOW);
      red_time    <= TIME_W'(DEF_GREEN + DEF_YELLOW);
      pend        <= '0;
      pending     <= 1'b0;
      cfg_ready   <= 1'b1;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (commit && pending) begin
        green_time  <= pend.green;
        yellow_time <= pend.yellow;
        red_time    <= pend.green + pend.yellow;
        pending     <= 1'b0;
        cfg_ready   <= 1'b1;
      end else if (cfg_valid && cfg_ready) begin
        if (timing_ok(offer, MIN_GREEN, MIN_YELLOW, MAX_T)) begin
          pend      <= offer;
          pending   <= 1'b1;
          cfg_ready <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_mode_ctrl.sv
// Mode FSM (off/clear/auto/manual/flash) driving the enable code, plus the timing register block.
module traffic_mode_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned DEF_GREEN    = DEFAULT_GREEN,
  parameter int unsigned DEF_YELLOW   = DEFAULT_YELLOW,
  parameter int unsigned MIN_GREEN    = DEFAULT_MIN_G,
  parameter int unsigned MIN_YELLOW   = DEFAULT_MIN_Y,
  parameter int unsigned MAX_T        = MAX_TIME,
  parameter int unsigned CLEAR_CYCLES = DEFAULT_CLEAR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_auto,
  input  logic              req_manual,
  input  logic              req_flash,
  input  logic              cfg_valid,
  input  logic [TIME_W-1:0] cfg_green,
  input  logic [TIME_W-1:0] cfg_yellow,
  output logic              cfg_ready,
  output logic              cfg_err,
  input  logic [2:0]        light_state,
  input  logic [TIME_W-1:0] lane2_time,
  output logic [2:0]        enable,
  output logic [TIME_W-1:0] greenTime,
  output logic [TIME_W-1:0] yellowTime,
  output logic [TIME_W-1:0] redTime,
  output logic              mode_busy
);

  localparam int unsigned CNT_W = (CLEAR_CYCLES > 2) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [2:0] S_OFF    = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_AUTO   = 3'd2;
  localparam logic [2:0] S_MANUAL = 3'd3;
  localparam logic [2:0] S_FLASH  = 3'd4;

  function automatic logic [2:0] en_code(input logic [2:0] s);
    case (s)
      S_AUTO:   return EN_AUTO;
      S_MANUAL: return EN_MANUAL;
      S_FLASH:  return EN_FLASH;
      default:  return EN_OFF;
    endcase
  endfunction

  logic [2:0]       state, state_nxt;
  logic [2:0]       target, target_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       enable_nxt;
  logic             busy_nxt;
  logic             req_any_c;
  logic [2:0]       req_mode_c;
  logic             pending;
  logic             commit_c;

  // Priority flash > manual > auto.
  always_comb begin
    req_any_c  = req_flash | req_manual | req_auto;
    req_mode_c = req_flash ? S_FLASH : (req_manual ? S_MANUAL : S_AUTO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_OFF;
      target    <= S_AUTO;
      cnt       <= '0;
      enable    <= EN_OFF;
      mode_busy <= 1'b0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      cnt       <= cnt_nxt;
      enable    <= enable_nxt;
      mode_busy <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    cnt_nxt    = cnt;
    enable_nxt = enable;
    busy_nxt   = mode_busy;
    case (state)
      S_OFF: begin
        state_nxt  = S_AUTO;
        enable_nxt = EN_AUTO;
        busy_nxt   = 1'b0;
      end
      S_AUTO, S_MANUAL, S_FLASH: begin
        if (req_any_c && (req_mode_c != state)) begin
          target_nxt = req_mode_c;
          state_nxt  = S_CLEAR;
          cnt_nxt    = CNT_W'(CLEAR_CYCLES - 1);
          enable_nxt = EN_OFF;
          busy_nxt   = 1'b1;
        end
      end
      S_CLEAR: begin
        // Late requests retarget without restarting the all-red interval.
        if (req_any_c) target_nxt = req_mode_c;
        if (cnt == '0) begin
          state_nxt  = target_nxt;
          enable_nxt = en_code(target_nxt);
          busy_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt  = S_OFF;
        enable_nxt = EN_OFF;
        busy_nxt   = 1'b0;
      end
    endcase
  end

  // In auto, new timings land on the RG->RY edge so the next GR starts fresh.
  assign commit_c = pending &&
                    ((state != S_AUTO) ||
                     ((light_state == LS_RG) && (lane2_time == TIME_W'(1))));

  timing_cfg_reg #(
    .DEF_GREEN  (DEF_GREEN),
    .DEF_YELLOW (DEF_YELLOW),
    .MIN_GREEN  (MIN_GREEN),
    .MIN_YELLOW (MIN_YELLOW),
    .MAX_T      (MAX_T)
  ) u_timing (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_green   (cfg_green),
    .cfg_yellow  (cfg_yellow),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .commit      (commit_c),
    .pending     (pending),
    .green_time  (greenTime),
    .yellow_time (yellowTime),
    .red_time    (redTime)
  );

endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// Directed vector bench for traffic_mode_ctrl: table of per-cycle stimulus/expectations plus corner sequences.
module tb_traffic_mode_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_auto, req_manual, req_flash;
  logic       cfg_valid;
  logic [6:0] cfg_green, cfg_yellow;
  logic       cfg_ready, cfg_err;
  logic [2:0] light_state;
  logic [6:0] lane2_time;
  logic [2:0] enable;
  logic [6:0] greenTime, yellowTime, redTime;
  logic       mode_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_mode_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_auto    (req_auto),
    .req_manual  (req_manual),
    .req_flash   (req_flash),
    .cfg_valid   (cfg_valid),
    .cfg_green   (cfg_green),
    .cfg_yellow  (cfg_yellow),
    .cfg_ready   (cfg_ready),
    .cfg_err     (cfg_err),
    .light_state (light_state),
    .lane2_time  (lane2_time),
    .enable      (enable),
    .greenTime   (greenTime),
    .yellowTime  (yellowTime),
    .redTime     (redTime),
    .mode_busy   (mode_busy)
  );

  typedef struct {
    logic       ra, rm, rf, cv;
    logic [6:0] cg, cy;
    logic [2:0] en;
    logic       busy, rdy, err;
    logic [6:0] g, y, r;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int ra, int rm, int rf, int cv, int cg, int cy,
                              int en, int busy, int rdy, int err, int g, int y, int r);
    vec_t v;
    v.ra = 1'(ra); v.rm = 1'(rm); v.rf = 1'(rf); v.cv = 1'(cv);
    v.cg = 7'(cg); v.cy = 7'(cy);
    v.en = 3'(en); v.busy = 1'(busy); v.rdy = 1'(rdy); v.err = 1'(err);
    v.g = 7'(g); v.y = 7'(y); v.r = 7'(r);
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int en, input int busy, input int rdy,
                           input int err, input int g, input int y, input int r);
    check({tag, ".enable"},     int'(enable),     en);
    check({tag, ".mode_busy"},  int'(mode_busy),  busy);
    check({tag, ".cfg_ready"},  int'(cfg_ready),  rdy);
    check({tag, ".cfg_err"},    int'(cfg_err),    err);
    check({tag, ".greenTime"},  int'(greenTime),  g);
    check({tag, ".yellowTime"}, int'(yellowTime), y);
    check({tag, ".redTime"},    int'(redTime),    r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_auto = 0; req_manual = 0; req_flash = 0;
    cfg_valid = 0; cfg_green = 0; cfg_yellow = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    light_state = LS_GR;
    lane2_time  = 7'd10;

    //      ra rm rf cv  cg  cy   en  busy rdy err  g  y  r
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b100,0,1,0, 30,3,33));   // OFF -> AUTO
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b100,0,1,0, 30,3,33));
    vecs.push_back(mk(0,1,0,0,  0, 0, 3'b000,1,1,0, 30,3,33));   // AUTO -> CLEAR
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b000,1,1,0, 30,3,33));
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b010,0,1,0, 30,3,33));   // MANUAL
    vecs.push_back(mk(0,1,0,0,  0, 0, 3'b010,0,1,0, 30,3,33));   // same mode ignored
    vecs.push_back(mk(1,0,1,0,  0, 0, 3'b000,1,1,0, 30,3,33));   // flash beats auto
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b000,1,1,0, 30,3,33));
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b001,0,1,0, 30,3,33));   // FLASH
    vecs.push_back(mk(0,1,0,0,  0, 0, 3'b000,1,1,0, 30,3,33));
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b000,1,1,0, 30,3,33));
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b010,0,1,0, 30,3,33));   // MANUAL
    vecs.push_back(mk(0,0,0,1, 20, 4, 3'b010,0,0,0, 30,3,33));   // accept 20/4
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b010,0,1,0, 20,4,24));   // commit
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b010,0,1,0, 20,4,24));
    vecs.push_back(mk(0,0,0,1, 96, 4, 3'b010,0,1,1, 20,4,24));   // sum 100 rejected
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b010,0,1,0, 20,4,24));
    vecs.push_back(mk(0,0,0,1,  3, 4, 3'b010,0,1,1, 20,4,24));   // green < min
    vecs.push_back(mk(0,0,0,1,  5, 2, 3'b010,0,0,0, 20,4,24));   // minima accepted
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b010,0,1,0,  5,2, 7));
    vecs.push_back(mk(0,0,0,1, 95, 4, 3'b010,0,0,0,  5,2, 7));   // sum 99 accepted
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b010,0,1,0, 95,4,99));
    vecs.push_back(mk(0,0,0,1,120,20, 3'b010,0,1,1, 95,4,99));   // 7-bit wrap case
    vecs.push_back(mk(0,0,0,1, 10, 1, 3'b010,0,1,1, 95,4,99));   // yellow < min
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b010,0,1,0, 95,4,99));
    vecs.push_back(mk(1,0,0,0,  0, 0, 3'b000,1,1,0, 95,4,99));   // MANUAL -> CLEAR(auto)
    vecs.push_back(mk(0,0,1,0,  0, 0, 3'b000,1,1,0, 95,4,99));   // retarget flash
    vecs.push_back(mk(0,1,0,0,  0, 0, 3'b010,0,1,0, 95,4,99));   // back to previous mode
    vecs.push_back(mk(1,0,0,0,  0, 0, 3'b000,1,1,0, 95,4,99));
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b000,1,1,0, 95,4,99));
    vecs.push_back(mk(0,0,0,0,  0, 0, 3'b100,0,1,0, 95,4,99));   // AUTO

    tick();
    tick();
    check_all("reset", 0, 0, 1, 0, 30, 3, 33);
    reset = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      req_auto   = vecs[i].ra;
      req_manual = vecs[i].rm;
      req_flash  = vecs[i].rf;
      cfg_valid  = vecs[i].cv;
      cfg_green  = vecs[i].cg;
      cfg_yellow = vecs[i].cy;
      tick();
      check_all($sformatf("v%0d", i), int'(vecs[i].en), int'(vecs[i].busy), int'(vecs[i].rdy),
                int'(vecs[i].err), int'(vecs[i].g), int'(vecs[i].y), int'(vecs[i].r));
    end
    idle_inputs();

    // Auto mode: commit only on RG with lane2_time == 1.
    cfg_valid = 1; cfg_green = 7'd40; cfg_yellow = 7'd5;
    light_state = LS_GR; lane2_time = 7'd10;
    tick();
    idle_inputs();
    check_all("auto.accept", 4, 0, 0, 0, 95, 4, 99);
    light_state = LS_GR; lane2_time = 7'd1;
    tick();
    check_all("auto.gr1", 4, 0, 0, 0, 95, 4, 99);
    light_state = LS_YR; lane2_time = 7'd1;
    tick();
    check_all("auto.yr1", 4, 0, 0, 0, 95, 4, 99);
    light_state = LS_RG; lane2_time = 7'd2;
    tick();
    check_all("auto.rg2", 4, 0, 0, 0, 95, 4, 99);
    light_state = LS_RY; lane2_time = 7'd1;
    tick();
    check_all("auto.ry1", 4, 0, 0, 0, 95, 4, 99);
    light_state = LS_RG; lane2_time = 7'd1;
    tick();
    check_all("auto.commit", 4, 0, 1, 0, 40, 5, 45);
    light_state = LS_RY; lane2_time = 7'd3;
    tick();
    check_all("auto.after", 4, 0, 1, 0, 40, 5, 45);

    // Pending timing survives a mode change and commits during CLEAR.
    light_state = LS_GR; lane2_time = 7'd10;
    cfg_valid = 1; cfg_green = 7'd50; cfg_yellow = 7'd6;
    tick();
    idle_inputs();
    check_all("keep.accept", 4, 0, 0, 0, 40, 5, 45);
    req_flash = 1;
    tick();
    idle_inputs();
    check_all("keep.toclear", 0, 1, 0, 0, 40, 5, 45);
    tick();
    check_all("keep.commit", 0, 1, 1, 0, 50, 6, 56);
    tick();
    check_all("keep.flash", 1, 0, 1, 0, 50, 6, 56);

    // Reset mid-CLEAR discards both the clearance and the pending timing.
    req_manual = 1; cfg_valid = 1; cfg_green = 7'd60; cfg_yellow = 7'd7;
    tick();
    idle_inputs();
    check_all("rst.pre", 0, 1, 0, 0, 50, 6, 56);
    reset = 1;
    tick();
    check_all("rst.hold", 0, 0, 1, 0, 30, 3, 33);
    reset = 0;
    tick();
    check_all("rst.auto", 4, 0, 1, 0, 30, 3, 33);
    tick();
    check_all("rst.nopend", 4, 0, 1, 0, 30, 3, 33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
